// File: rtl/step_pulse_debouncer_if.sv
//------------------------------------------------------------------------------
// Module      : step_pulse_debouncer_if
// Description : Sample-enable / button-in and step-pulse-out signal bundle for
//               the manual-step debouncer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface step_pulse_debouncer_if #(
  parameter int CW = 8
);
  logic          tick;
  logic          btn_raw;
  logic          step_pulse;
  logic          btn_level;
  logic [CW-1:0] press_count;

  // Master supplies the sample enable and raw button, consumes the results
  modport master (
    output tick,
    output btn_raw,
    input  step_pulse,
    input  btn_level,
    input  press_count
  );

  // Slave is the debouncer itself
  modport slave (
    input  tick,
    input  btn_raw,
    output step_pulse,
    output btn_level,
    output press_count
  );
endinterface

`default_nettype wire

// File: rtl/step_pulse_debouncer.sv
//------------------------------------------------------------------------------
// Module      : step_pulse_debouncer
// Description : Samples a bouncy push-button on divider ticks, debounces it
//               with a four-state FSM and emits one single-clock step pulse
//               per accepted press, plus debounced level and press counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module step_pulse_debouncer #(
  parameter int STABLE_N = 4,
  parameter int CW       = 8
) (
  input  wire logic             clock,
  input  wire logic             reset,
  step_pulse_debouncer_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] c_STABLE_N = CNT_W'(STABLE_N);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS_W = 2'd1,
    S_PRESSED = 2'd2,
    S_REL_W   = 2'd3
  } state_t;

  logic             r_sync_q1;
  logic             r_sync;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             r_step_pulse;
  logic             r_btn_level;
  logic [CW-1:0]    r_press_count;

  assign w_cnt_inc = r_cnt + c_CNT_ONE;

  // Two-flop synchronizer for the asynchronous button; shifts every clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync_q1 <= 1'b0;
      r_sync    <= 1'b0;
    end else begin
      r_sync_q1 <= bus.btn_raw;
      r_sync    <= r_sync_q1;
    end
  end

  // Next-state / stable-count / accept decode; only tick cycles move the FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (bus.tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_sync) begin
            if (STABLE_N == 1) begin
              w_state_nxt = S_PRESSED;
              w_cnt_nxt   = '0;
              w_accept    = 1'b1;
            end else begin
              w_state_nxt = S_PRESS_W;
              w_cnt_nxt   = c_CNT_ONE;
            end
          end
        end
        S_PRESS_W: begin
          if (r_sync) begin
            if (w_cnt_inc == c_STABLE_N) begin
              w_state_nxt = S_PRESSED;
              w_cnt_nxt   = '0;
              w_accept    = 1'b1;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            // bounce during press qualification: drop it silently
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        S_PRESSED: begin
          if (!r_sync) begin
            if (STABLE_N == 1) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_REL_W;
              w_cnt_nxt   = c_CNT_ONE;
            end
          end
        end
        S_REL_W: begin
          if (!r_sync) begin
            if (w_cnt_inc == c_STABLE_N) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            // bounce during release: still pressed, no second pulse
            w_state_nxt = S_PRESSED;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_step_pulse  <= 1'b0;
      r_btn_level   <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_step_pulse <= w_accept;
      r_btn_level  <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_REL_W);
      if (w_accept) begin
        r_press_count <= r_press_count + 1'b1;
      end
    end
  end

  assign bus.step_pulse  = r_step_pulse;
  assign bus.btn_level   = r_btn_level;
  assign bus.press_count = r_press_count;

endmodule

`default_nettype wire
